// File: rtl/bcd_down_timer_if.sv
// rtl/bcd_down_timer_if.sv - load/enable/status bundle for the BCD down-timer
interface bcd_down_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   q;
  logic                  zero;
  logic                  done;
  logic                  busy;

  modport master (
    output load, load_val, en,
    input  q, zero, done, busy
  );

  modport slave (
    input  load, load_val, en,
    output q, zero, done, busy
  );
endinterface

// File: rtl/bcd_down_timer.sv
// rtl/bcd_down_timer.sv - multi-digit BCD down-counter with terminal-count pulse; optional BCD_DOWN_TIMER_AUTO_RELOAD_EN
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  bcd_down_timer_if.slave     bus
);
  localparam int W = 4 * DIGITS;

  // IDLE is kept only so the encoding is complete; reset goes straight to EXPIRED.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   q_q;
  logic [W-1:0]   reload_q;
  logic           zero_q;
  logic           done_q;
  logic           busy_q;

  logic [W-1:0]   clamp_d;
  logic [W-1:0]   dec_d;
  logic           borrow_d;

  // Saturate every loaded digit to 9 so q always holds legal BCD.
  always_comb begin
    clamp_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        clamp_d[4*i +: 4] = 4'd9;
      end else begin
        clamp_d[4*i +: 4] = bus.load_val[4*i +: 4];
      end
    end
  end

  // One-step BCD decrement with the borrow rippling through all digits in one cycle.
  always_comb begin
    dec_d    = q_q;
    borrow_d = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow_d) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          dec_d[4*i +: 4] = 4'd9;
        end else begin
          dec_d[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow_d        = 1'b0;
        end
      end
    end
  end

  // State machine with registered count and status flags; load beats en beats hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= EXPIRED;
      q_q      <= '0;
      reload_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (bus.load) begin
      q_q      <= clamp_d;
      reload_q <= clamp_d;
      done_q   <= 1'b0;
      if (clamp_d != '0) begin
        state_q <= COUNT;
        zero_q  <= 1'b0;
        busy_q  <= 1'b1;
      end else begin
        state_q <= EXPIRED;
        zero_q  <= 1'b1;
        busy_q  <= 1'b0;
      end
    end else if (bus.en) begin
      case (state_q)
        COUNT: begin
          q_q <= dec_d;
          // q is never zero in COUNT, so dec_d cannot underflow past 00.
          if (dec_d == '0) begin
            state_q <= EXPIRED;
            zero_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            done_q  <= 1'b0;
          end
        end
        EXPIRED: begin
          done_q <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
          // Periodic mode: restart from the last loaded value; a zero reload stays parked.
          if (reload_q != '0) begin
            q_q     <= reload_q;
            state_q <= COUNT;
            zero_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
`endif
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end else begin
      done_q <= 1'b0;
    end
  end

  assign bus.q    = q_q;
  assign bus.zero = zero_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb/tb_bcd_down_timer.sv - randomized self-checking bench for bcd_down_timer against a decimal model
module tb_bcd_down_timer;
  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_down_timer_if #(.DIGITS(DIGITS)) bus_if ();

  bcd_down_timer #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal value of a BCD word after saturating each digit to 9.
  function automatic int clamp_to_int(input logic [W-1:0] v);
    int r;
    int p;
    int d;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference model: the count as a plain integer plus a running flag.
  int m_q;
  int m_reload;
  bit m_run;
  bit m_done;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_q      <= 0;
      m_reload <= 0;
      m_run    <= 1'b0;
      m_done   <= 1'b0;
      m_valid  <= 1'b1;
    end else if (bus_if.load) begin
      m_q      <= clamp_to_int(bus_if.load_val);
      m_reload <= clamp_to_int(bus_if.load_val);
      m_run    <= (clamp_to_int(bus_if.load_val) != 0);
      m_done   <= 1'b0;
    end else if (bus_if.en && m_run) begin
      m_q    <= m_q - 1;
      m_done <= (m_q == 1);
      m_run  <= (m_q != 1);
    end else begin
      m_done <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      if (bus_if.en && m_reload != 0) begin
        m_q   <= m_reload;
        m_run <= 1'b1;
      end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q",    bus_if.q,    int_to_bcd(m_q));
      check("model_zero", W'(bus_if.zero), W'(m_q == 0));
      check("model_done", W'(bus_if.done), W'(m_done));
      check("model_busy", W'(bus_if.busy), W'(m_run));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [W-1:0] lv, input logic e);
    bus_if.load     = ld;
    bus_if.load_val = lv;
    bus_if.en       = e;
  endtask

  logic [W-1:0] seq12 [12] = '{12'h011, 12'h010, 12'h009, 12'h008, 12'h007, 12'h006,
                               12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};
  logic [W-1:0] per3  [8]  = '{12'h002, 12'h001, 12'h000, 12'h003,
                               12'h002, 12'h001, 12'h000, 12'h003};

  initial begin
    rst = 1'b0;
    drive(1'b1, 12'h042, 1'b0);
    step();
    step();
    check("rst_q",    bus_if.q, 12'h000);
    check("rst_zero", W'(bus_if.zero), W'(1));
    check("rst_busy", W'(bus_if.busy), W'(0));
    check("rst_done", W'(bus_if.done), W'(0));

    rst = 1'b1;
    drive(1'b1, 12'h012, 1'b0);
    step();
    check("load12_q",    bus_if.q, 12'h012);
    check("load12_busy", W'(bus_if.busy), W'(1));
    check("load12_zero", W'(bus_if.zero), W'(0));
    drive(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("cnt12_q",    bus_if.q, seq12[i]);
      check("cnt12_done", W'(bus_if.done), W'(i == 11));
      check("cnt12_busy", W'(bus_if.busy), W'(i != 11));
    end
    check("cnt12_zero", W'(bus_if.zero), W'(1));
    step();
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    check("reload12_q",    bus_if.q, 12'h012);
    check("reload12_busy", W'(bus_if.busy), W'(1));
`else
    check("hold0_q",    bus_if.q, 12'h000);
    check("hold0_done", W'(bus_if.done), W'(0));
`endif

    drive(1'b1, 12'h100, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b1);
    step();
    check("borrow_q", bus_if.q, 12'h099);

    drive(1'b1, 12'h0AF, 1'b0);
    step();
    check("clamp_q", bus_if.q, 12'h099);

    drive(1'b1, 12'h005, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b1); step(); check("gate1_q", bus_if.q, 12'h004);
    drive(1'b0, 12'h000, 1'b0); step(); check("gate2_q", bus_if.q, 12'h004);
    drive(1'b0, 12'h000, 1'b1); step(); check("gate3_q", bus_if.q, 12'h003);
    drive(1'b0, 12'h000, 1'b0); step(); check("gate4_q", bus_if.q, 12'h003);

    drive(1'b1, 12'h001, 1'b0);
    step();
    drive(1'b0, 12'h000, 1'b1);
    step();
    check("one_q",    bus_if.q, 12'h000);
    check("one_done", W'(bus_if.done), W'(1));
    drive(1'b1, 12'h000, 1'b1);
    step();
    check("load0_q",    bus_if.q, 12'h000);
    check("load0_done", W'(bus_if.done), W'(0));
    check("load0_zero", W'(bus_if.zero), W'(1));
    drive(1'b0, 12'h000, 1'b1);
    step();
    step();
    check("exp_en_q",    bus_if.q, 12'h000);
    check("exp_en_done", W'(bus_if.done), W'(0));
    check("exp_en_busy", W'(bus_if.busy), W'(0));

    drive(1'b1, 12'h002, 1'b1);
    step();
    drive(1'b0, 12'h000, 1'b1);
    step();
    check("coll_pre_q", bus_if.q, 12'h001);
    drive(1'b1, 12'h030, 1'b1);
    step();
    check("coll_q",    bus_if.q, 12'h030);
    check("coll_done", W'(bus_if.done), W'(0));
    check("coll_busy", W'(bus_if.busy), W'(1));

    drive(1'b1, 12'h009, 1'b1);
    step();
    drive(1'b0, 12'h000, 1'b1);
    step();
    step();
    check("midrst_pre_q", bus_if.q, 12'h007);
    rst = 1'b0;
    step();
    check("midrst_q",    bus_if.q, 12'h000);
    check("midrst_done", W'(bus_if.done), W'(0));
    check("midrst_busy", W'(bus_if.busy), W'(0));
    rst = 1'b1;

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
    drive(1'b1, 12'h003, 1'b1);
    step();
    drive(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("per3_q",    bus_if.q, per3[i]);
      check("per3_done", W'(bus_if.done), W'(i == 2 || i == 6));
    end
`endif

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      bus_if.load = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus_if.load_val = W'($urandom);
      end else begin
        bus_if.load_val = W'($urandom_range(0, 'h030));
      end
      bus_if.en = ($urandom_range(0, 3) != 0);
      step();
    end

    rst = 1'b1;
    drive(1'b0, 12'h000, 1'b0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
